mark_tracker: RTL and testbench
===============================

Name: mark_tracker

Overview:
- Downstream consumer of the rotating-disk red-mark stage.
- Takes its two mark sensors: sensor_b fires on left rotation, sensor_a fires on right rotation.
- Synchronises and debounces both sensors, then converts mark arrivals into single-cycle event pulses.
- Maintains a signed revolution count, a direction state machine, a stall watchdog and a sticky error flag for the supervisory logic.

Parameters:
- DEB_CYCLES, 4, consecutive cycles a synchronised sensor level must differ from its debounced level before it is accepted (≥2).
- CNT_W, 16, width of the signed revolution counter.
- TIMEOUT, 1000, cycles without an accepted mark event before a moving state declares stall.
- TMR_W, 16, width of the watchdog timer (must hold TIMEOUT).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sensor_a  in  1  raw mark sensor A, asynchronous to clk.
- sensor_b  in  1  raw mark sensor B, asynchronous to clk.
- clear  in  1  synchronous clear of counts, flags and FSM.
- mark_a_pulse  out  1  one-cycle pulse on accepted rising edge of A.
- mark_b_pulse  out  1  one-cycle pulse on accepted rising edge of B.
- dir  out  2  00 idle, 01 left, 10 right, 11 stalled.
- rev_count  out  CNT_W  signed net revolutions; +1 per B event, −1 per A event.
- stall  out  1  high while the FSM is in ST_STALL.
- err  out  1  sticky: A and B accepted in the same cycle.

Behaviour:
Reset and clear:
- Reset (async assert, sync release): all flops 0; outputs 0; FSM = ST_IDLE.
- clear: zeroes rev_count, err, timer, pulses. Sets FSM = ST_IDLE. Does not touch the synchronisers or debouncers.
- clear has priority over a same-cycle event; that event is dropped.

Input path, per sensor:
- 2-flop synchroniser, then debouncer.
- Debouncer: counter increments on each edge where the synchronised value ≠ the debounced level, and resets to 0 when they are equal.
- On the edge where the counter == DEB_CYCLES−1 and the values still differ, the debounced level flips.
- Pulse register is set on the same edge as a 0→1 flip, for exactly one cycle. No pulse on a 1→0 flip.

Latency (edge 0 = first edge sampling raw high):
- mark_x_pulse is high after edge DEB_CYCLES+1.
- rev_count, dir and FSM update at edge DEB_CYCLES+2.
- Raw pulses shorter than DEB_CYCLES cycles are rejected.

Events:
- evB = mark_b_pulse & ~mark_a_pulse.
- evA = mark_a_pulse & ~mark_b_pulse.
- Both pulses in the same cycle: err←1 (sticky until clear/reset); count, timer and FSM unchanged.

Counter:
- rev_count saturates at +2^(CNT_W−1)−1 and −2^(CNT_W−1).
- An event at the limit leaves the value unchanged. There is no wrap.

FSM states: ST_IDLE, ST_LEFT, ST_RIGHT, ST_STALL.
- Any state: evB → ST_LEFT, evA → ST_RIGHT. The timer is cleared on every event.
- ST_LEFT / ST_RIGHT with no event: timer +1 per cycle. When the timer reaches TIMEOUT−1 and no event is present, go to ST_STALL; the timer holds.
- ST_IDLE: timer held at 0; never stalls.
- ST_STALL: exit only on an event or clear.
- dir encodes the state. dir and stall are registered and decoded from the state register.

Decomposition:
- Shared package mark_pkg holds:
  - state enum (ST_IDLE=0, ST_LEFT=1, ST_RIGHT=2, ST_STALL=3);
  - DIR_* constants matching the dir encoding;
  - default DEB_CYCLES and TIMEOUT.
- One sub-module, mark_debounce, contains synchroniser + debouncer + rising pulse. It is instantiated twice.

Test Plan:
- Reset: drive rst_n low mid-run with rev_count=5 and FSM in ST_LEFT → all outputs 0 immediately, dir=00.
- Glitch filter: DEB_CYCLES=4; sensor_b high for 3 cycles → no pulse, rev_count 0. Sensor_b held for 6 cycles → mark_b_pulse high one cycle after edge 5, rev_count=1 and dir=01 after edge 6.
- Direction: 3 B events then 2 A events → rev_count=1, dir=10. Then 1 B event → dir=01, rev_count=2.
- Simultaneous: both sensors rise on the same edge and are held 6 cycles → err=1, rev_count unchanged. Subsequent clear → err=0, rev_count=0, dir=00.
- Stall: TIMEOUT=10, one B event then idle → stall=1 and dir=11 exactly 10 cycles after the event-update edge. Next A event → stall=0, dir=10, rev_count=0.
- Saturation: CNT_W=4, 9 B events → rev_count=7. Then 1 A event → rev_count=6.

Source files
------------

// File: rtl/mark_pkg.sv
// Shared types and defaults for the mark tracker: FSM state encoding,
// direction codes and default parameter values.
package mark_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_STALL = 2'd3
  } state_e;

  localparam logic [1:0] DIR_IDLE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_STALL = 2'b11;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_TIMEOUT    = 1000;
  localparam int DEF_TMR_W      = 16;

  // dir is a pure decode of the state register
  function automatic logic [1:0] state_to_dir(input state_e s);
    logic [1:0] d;
    d = DIR_IDLE;
    case (s)
      ST_IDLE:  d = DIR_IDLE;
      ST_LEFT:  d = DIR_LEFT;
      ST_RIGHT: d = DIR_RIGHT;
      ST_STALL: d = DIR_STALL;
      default:  d = DIR_IDLE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mark_tracker_if.sv
// Sensor inputs, clear and status outputs of the mark tracker, bundled
// so the supervisory side and the tracker share one connection.
interface mark_tracker_if import mark_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
);

  logic                    sensor_a;
  logic                    sensor_b;
  logic                    clear;
  logic                    mark_a_pulse;
  logic                    mark_b_pulse;
  logic [1:0]              dir;
  logic signed [CNT_W-1:0] rev_count;
  logic                    stall;
  logic                    err;

  modport master (
    output sensor_a, sensor_b, clear,
    input  mark_a_pulse, mark_b_pulse, dir, rev_count, stall, err
  );

  modport slave (
    input  sensor_a, sensor_b, clear,
    output mark_a_pulse, mark_b_pulse, dir, rev_count, stall, err
  );

endinterface

// File: rtl/mark_debounce.sv
// One sensor channel: two-flop synchroniser, run-length debouncer and a
// single-cycle pulse on each accepted low-to-high transition.
module mark_debounce import mark_pkg::*; #(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sensor,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // clear only suppresses the pulse; the filtered level keeps tracking the sensor
  always_comb begin
    sync1_d = sensor;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        pulse_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (clear) begin
      pulse_d = 1'b0;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/mark_tracker.sv
// Turns debounced mark pulses into a saturating signed revolution count,
// a direction FSM with stall watchdog and a sticky coincidence error.
module mark_tracker import mark_pkg::*; #(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TMR_W      = DEF_TMR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mark_tracker_if.slave  bus
);

  localparam logic signed [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic pulse_a;
  logic pulse_b;
  logic ev_a;
  logic ev_b;
  logic ev_both;

  state_e                  state_q, state_d;
  logic signed [CNT_W-1:0] count_q, count_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    err_q, err_d;

  mark_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (bus.clear),
    .sensor (bus.sensor_a),
    .pulse  (pulse_a)
  );

  mark_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (bus.clear),
    .sensor (bus.sensor_b),
    .pulse  (pulse_b)
  );

  assign ev_a    = pulse_a & ~pulse_b;
  assign ev_b    = pulse_b & ~pulse_a;
  assign ev_both = pulse_a & pulse_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // clear beats any event; a coincident A+B only raises err and freezes the rest
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    err_d   = err_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      count_d = '0;
      timer_d = '0;
      err_d   = 1'b0;
    end else if (ev_both) begin
      err_d = 1'b1;
    end else if (ev_b) begin
      state_d = ST_LEFT;
      timer_d = '0;
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end
    end else if (ev_a) begin
      state_d = ST_RIGHT;
      timer_d = '0;
      if (count_q != CNT_MIN) begin
        count_d = count_q - CNT_ONE;
      end
    end else begin
      case (state_q)
        ST_LEFT, ST_RIGHT: begin
          if (timer_q == TMR_LAST) begin
            state_d = ST_STALL;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_IDLE:  timer_d = '0;
        default:  timer_d = timer_q;
      endcase
    end
  end

  assign bus.mark_a_pulse = pulse_a;
  assign bus.mark_b_pulse = pulse_b;
  assign bus.dir          = state_to_dir(state_q);
  assign bus.stall        = (state_q == ST_STALL);
  assign bus.rev_count    = count_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_mark_tracker.sv
// Bench for mark_tracker: directed scenarios with literal expectations plus
// random sensor traffic, all checked every cycle against a behavioural model.
module tb_mark_tracker;
  import mark_pkg::*;

  localparam int DEB     = 4;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 10;
  localparam int TMR_W   = 8;
  localparam int CNT_MAX = (2 ** (CNT_W - 1)) - 1;
  localparam int CNT_MIN = -(2 ** (CNT_W - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mark_tracker_if #(.CNT_W(CNT_W)) bus ();

  mark_tracker #(
    .DEB_CYCLES (DEB),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .TMR_W      (TMR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nVectors     = 0;
  int nMiscompares = 0;
  bit checkEn      = 1'b0;

  // model state: raw sample history per sensor (bit 0 newest), filtered levels, pulses
  logic [DEB+1:0] histA, histB;
  bit levA, levB, pA, pB, mErr;
  int mCount, mMode, mSince;

  function automatic void cmp(input string name, input int actual, input int expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic void modelReset();
    histA = '0; histB = '0;
    levA = 1'b0; levB = 1'b0; pA = 1'b0; pB = 1'b0; mErr = 1'b0;
    mCount = 0; mMode = 0; mSince = 0;
  endfunction

  // a sensor is accepted once the last DEB synchronised samples all disagree with the level
  function automatic void debStep(input bit raw, input bit clr, inout logic [DEB+1:0] hist,
                                  inout bit lev, output bit pulse);
    logic [DEB-1:0] win;
    bit flip;
    hist = {hist[DEB:0], raw};
    win  = hist[DEB+1:2];
    flip = lev ? (win == '0) : (&win);
    if (flip) lev = ~lev;
    pulse = flip && lev && !clr;
  endfunction

  function automatic void modelStep();
    bit a, b, clr;
    a   = bus.sensor_a;
    b   = bus.sensor_b;
    clr = bus.clear;
    if (clr) begin
      mCount = 0; mErr = 1'b0; mMode = 0; mSince = 0;
    end else if (pA && pB) begin
      mErr = 1'b1;
    end else if (pB) begin
      if (mCount < CNT_MAX) mCount++;
      mMode = 1; mSince = 0;
    end else if (pA) begin
      if (mCount > CNT_MIN) mCount--;
      mMode = 2; mSince = 0;
    end else if (mMode != 0 && mSince < TIMEOUT) begin
      mSince++;
    end
    debStep(a, clr, histA, levA, pA);
    debStep(b, clr, histB, levB, pB);
  endfunction

  function automatic int expDir();
    return (mMode != 0 && mSince >= TIMEOUT) ? 3 : mMode;
  endfunction

  task automatic checkOutput();
    cmp("mark_a_pulse", int'(bus.mark_a_pulse), int'(pA));
    cmp("mark_b_pulse", int'(bus.mark_b_pulse), int'(pB));
    cmp("rev_count",    int'(bus.rev_count),    mCount);
    cmp("dir",          int'(bus.dir),          expDir());
    cmp("stall",        int'(bus.stall),        int'(expDir() == 3));
    cmp("err",          int'(bus.err),          int'(mErr));
  endtask

  task automatic applyStimulus(input bit a, input bit b, input bit clr);
    @(negedge clk);
    bus.sensor_a = a;
    bus.sensor_b = b;
    bus.clear    = clr;
    @(posedge clk);
  endtask

  task automatic holdFor(input bit a, input bit b, input int n);
    repeat (n) applyStimulus(a, b, 1'b0);
  endtask

  task automatic markEvent(input bit a, input bit b);
    holdFor(a, b, 5);
    holdFor(1'b0, 1'b0, 4);
  endtask

  task automatic settleClear();
    holdFor(1'b0, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n) modelStep();
  end

  initial forever begin
    @(negedge rst_n);
    modelReset();
  end

  initial forever begin
    @(negedge clk);
    if (checkEn) checkOutput();
  end

  initial begin
    bus.sensor_a = 1'b0;
    bus.sensor_b = 1'b0;
    bus.clear    = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_rev_count", int'(bus.rev_count), 0);
    cmp("reset_dir",       int'(bus.dir),       0);
    @(negedge clk);
    rst_n   = 1'b1;
    checkEn = 1'b1;

    $display("[TB] glitch filter and latency");
    holdFor(1'b0, 1'b1, 3);
    holdFor(1'b0, 1'b0, 8);
    #1 cmp("glitch_rev_count", int'(bus.rev_count), 0);
    holdFor(1'b0, 1'b1, 6);
    #1;
    cmp("pulse_b_after_edge5", int'(bus.mark_b_pulse), 1);
    cmp("rev_before_edge6",    int'(bus.rev_count),    0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    cmp("rev_after_edge6",   int'(bus.rev_count),    1);
    cmp("dir_after_edge6",   int'(bus.dir),          1);
    cmp("pulse_b_one_cycle", int'(bus.mark_b_pulse), 0);
    settleClear();

    $display("[TB] direction");
    repeat (3) markEvent(1'b0, 1'b1);
    repeat (2) markEvent(1'b1, 1'b0);
    #1;
    cmp("dir_rev_count", int'(bus.rev_count), 1);
    cmp("dir_right",     int'(bus.dir),       2);
    markEvent(1'b0, 1'b1);
    #1;
    cmp("dir_rev_count2", int'(bus.rev_count), 2);
    cmp("dir_left",       int'(bus.dir),       1);

    $display("[TB] simultaneous marks");
    holdFor(1'b1, 1'b1, 6);
    holdFor(1'b0, 1'b0, 6);
    #1;
    cmp("sim_err",       int'(bus.err),       1);
    cmp("sim_rev_count", int'(bus.rev_count), 2);
    settleClear();
    #1;
    cmp("clr_err",       int'(bus.err),       0);
    cmp("clr_rev_count", int'(bus.rev_count), 0);
    cmp("clr_dir",       int'(bus.dir),       0);

    $display("[TB] stall watchdog");
    holdFor(1'b0, 1'b1, 6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    holdFor(1'b0, 1'b0, TIMEOUT - 1);
    #1 cmp("stall_early", int'(bus.stall), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    cmp("stall_set", int'(bus.stall), 1);
    cmp("stall_dir", int'(bus.dir),   3);
    markEvent(1'b1, 1'b0);
    #1;
    cmp("stall_exit",      int'(bus.stall),     0);
    cmp("stall_exit_dir",  int'(bus.dir),       2);
    cmp("stall_exit_rev",  int'(bus.rev_count), 0);

    $display("[TB] saturation");
    settleClear();
    repeat (9) markEvent(1'b0, 1'b1);
    #1 cmp("sat_max", int'(bus.rev_count), 7);
    markEvent(1'b1, 1'b0);
    #1 cmp("sat_down", int'(bus.rev_count), 6);

    $display("[TB] reset mid-run");
    settleClear();
    repeat (5) markEvent(1'b0, 1'b1);
    #1;
    cmp("pre_reset_rev", int'(bus.rev_count), 5);
    cmp("pre_reset_dir", int'(bus.dir),       1);
    #1 rst_n = 1'b0;
    #1;
    cmp("async_rev",   int'(bus.rev_count), 0);
    cmp("async_dir",   int'(bus.dir),       0);
    cmp("async_stall", int'(bus.stall),     0);
    cmp("async_err",   int'(bus.err),       0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
      end else if (r < 10) begin
        holdFor(1'b0, 1'b0, int'($urandom_range(12, 20)));
      end else begin
        holdFor(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                int'($urandom_range(1, 8)));
      end
    end
    holdFor(1'b0, 1'b0, 10);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
